// File: rtl/ref_trim_pkg.sv
// Shared types and helpers for the reference trim sequencer: state encoding,
// counter sizing and the per-channel trim slice.
`ifndef REF_TRIM_PKG_SV
`define REF_TRIM_PKG_SV

// Bit range of channel k in a bus of tw-bit trim words.
`define REF_TRIM_CH(k, tw) ((k) * (tw)) +: (tw)

package ref_trim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_ENABLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_READY  = 3'd4,
    ST_OFF    = 3'd5,
    ST_FAULT  = 3'd6
  } state_t;

  // Bits needed to hold 0..maxval, never less than one bit.
  function automatic int width_for(input int maxval);
    return (maxval < 1) ? 1 : $clog2(maxval + 1);
  endfunction

  function automatic int cnt_width(input int settle, input int timeout);
    return width_for((settle > timeout) ? settle : timeout);
  endfunction

endpackage

`endif

// File: rtl/ref_sync2.sv
// Two-flop synchroniser for a slow asynchronous level, reset to 0.
module ref_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ref_trim_seq.sv
// Power-up sequencer and OTP trim loader for NCH analog reference cells.
// Optional test trim override: define REF_TRIM_SEQ_TESTOVR_EN.
module ref_trim_seq
  import ref_trim_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int TW          = 7,
  parameter int SETTLE_CYC  = 1024,
  parameter int TIMEOUT_CYC = 4096,
  parameter int RETRY_MAX   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NCH*TW-1:0] trim_in,
  input  logic              trim_vld,
  input  logic [NCH-1:0]    ten,
  input  logic              refok,
`ifdef REF_TRIM_SEQ_TESTOVR_EN
  input  logic              tm_ovr,
  input  logic [NCH*TW-1:0] tm_trim,
`endif
  output logic              en,
  output logic [NCH*TW-1:0] trim_out,
  output logic [NCH-1:0]    ten_out,
  output logic              ready,
  output logic              fault,
  output logic [2:0]        state_o
);

  localparam int CW = cnt_width(SETTLE_CYC, TIMEOUT_CYC);
  localparam int RW = width_for(RETRY_MAX);
  localparam int LW = width_for(NCH);

  state_t            state, next;
  logic [CW-1:0]     cnt;
  logic [RW-1:0]     retry;
  logic [LW-1:0]     ld_idx;
  logic              loading;
  logic [NCH*TW-1:0] shadow;
  logic              refok_s;
`ifdef REF_TRIM_SEQ_TESTOVR_EN
  logic              ovr_act;
`endif

  ref_sync2 u_refok_sync (
    .clk (clk),
    .rst (rst),
    .d   (refok),
    .q   (refok_s)
  );

  assign state_o = state;

  always_comb begin
    next = state;
    unique case (state)
      ST_IDLE:   if (start) next = ST_LOAD;
      ST_LOAD:   if (loading && ld_idx == LW'(NCH)) next = ST_ENABLE;
      ST_ENABLE: if (cnt == CW'(SETTLE_CYC - 1)) next = ST_CHECK;
      ST_CHECK: begin
        if (refok_s) begin
          next = ST_READY;
        end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
          next = (retry < RW'(RETRY_MAX)) ? ST_OFF : ST_FAULT;
        end
      end
      ST_OFF:    if (cnt == CW'(SETTLE_CYC - 1)) next = ST_ENABLE;
      ST_READY:  if (!refok_s) next = ST_CHECK;
      ST_FAULT:  next = ST_FAULT;
      default:   next = ST_IDLE;
    endcase
    // Dropping the request overrides every transition.
    if (!start) next = ST_IDLE;
  end

  // Outputs are registered from the next state so the analog side never
  // sees decode glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      retry   <= '0;
      en      <= 1'b0;
      ready   <= 1'b0;
      fault   <= 1'b0;
      ten_out <= '0;
    end else begin
      state <= next;
      if (next != state) begin
        cnt <= '0;
      end else if (state == ST_ENABLE || state == ST_CHECK || state == ST_OFF) begin
        cnt <= cnt + CW'(1);
      end
      if (next == ST_IDLE) begin
        retry <= '0;
      end else if (state == ST_CHECK && next == ST_OFF) begin
        retry <= retry + RW'(1);
      end
      en      <= (next == ST_ENABLE) || (next == ST_CHECK) || (next == ST_READY);
      ready   <= (next == ST_READY);
      fault   <= (next == ST_FAULT);
      ten_out <= (next == ST_READY) ? ten : '0;
    end
  end

  // Channel 0 goes out on the capture edge itself; later channels come from
  // the shadow copy, one per cycle, so lower channels stay put meanwhile.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow   <= '0;
      trim_out <= '0;
      loading  <= 1'b0;
      ld_idx   <= '0;
`ifdef REF_TRIM_SEQ_TESTOVR_EN
      ovr_act  <= 1'b0;
`endif
    end else begin
      if (state == ST_LOAD && start) begin
        if (!loading) begin
          if (trim_vld) begin
            shadow                       <= trim_in;
            trim_out[`REF_TRIM_CH(0, TW)] <= trim_in[`REF_TRIM_CH(0, TW)];
            loading                      <= 1'b1;
            ld_idx                       <= LW'(1);
          end
        end else if (ld_idx != LW'(NCH)) begin
          for (int k = 0; k < NCH; k++) begin
            if (ld_idx == LW'(k)) trim_out[`REF_TRIM_CH(k, TW)] <= shadow[`REF_TRIM_CH(k, TW)];
          end
          ld_idx <= ld_idx + LW'(1);
        end
      end else begin
        loading <= 1'b0;
        ld_idx  <= '0;
      end
`ifdef REF_TRIM_SEQ_TESTOVR_EN
      if (state == ST_READY && tm_ovr) begin
        trim_out <= tm_trim;
        ovr_act  <= 1'b1;
      end else if (ovr_act) begin
        trim_out <= shadow;
        ovr_act  <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ref_trim_seq.sv
// Bench for ref_trim_seq: directed phases with randomized words, refok timing
// and test enables, checked against an interval-arithmetic timeline model.
module tb_ref_trim_seq;

  localparam int NCH     = 4;
  localparam int TW      = 7;
  localparam int SETTLE  = 16;
  localparam int TIMEOUT = 32;
  localparam int RMAX    = 2;
  localparam int TRW     = NCH * TW;
  localparam int NEVER   = 1 << 30;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_ENABLE = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_READY  = 3'd4;
  localparam logic [2:0] S_OFF    = 3'd5;
  localparam logic [2:0] S_FAULT  = 3'd6;

  // ---------------- clock / reset / DUT ----------------
  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [TRW-1:0] trim_in;
  logic           trim_vld;
  logic [NCH-1:0] ten;
  logic           refok;
  logic           en;
  logic [TRW-1:0] trim_out;
  logic [NCH-1:0] ten_out;
  logic           ready;
  logic           fault;
  logic [2:0]     state_o;
`ifdef REF_TRIM_SEQ_TESTOVR_EN
  logic           tm_ovr;
  logic [TRW-1:0] tm_trim;
`endif

  always #5 clk = ~clk;

  ref_trim_seq #(
    .NCH(NCH), .TW(TW), .SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TIMEOUT), .RETRY_MAX(RMAX)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .trim_in  (trim_in),
    .trim_vld (trim_vld),
    .ten      (ten),
    .refok    (refok),
`ifdef REF_TRIM_SEQ_TESTOVR_EN
    .tm_ovr   (tm_ovr),
    .tm_trim  (tm_trim),
`endif
    .en       (en),
    .trim_out (trim_out),
    .ten_out  (ten_out),
    .ready    (ready),
    .fault    (fault),
    .state_o  (state_o)
  );

  // ---------------- scoreboard state ----------------
  int             n_chk = 0;
  int             n_err = 0;
  int             cyc = 0;
  logic [TRW-1:0] cur_trim;
  int             e_st[0:RMAX];
  int             n_att;
  int             rdy_c;
  int             flt_c;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Timeline of one start-up with the strobe at cycle t and refok rising at
  // cycle r (r < 0: never). Each attempt is SETTLE on, TIMEOUT checking, then
  // SETTLE off before the next; refok is seen two cycles after it rises.
  task automatic plan(input int t, input int r);
    int e;
    int cs;
    int ce;
    rdy_c = NEVER;
    flt_c = NEVER;
    n_att = 0;
    e = t + NCH + 1;
    for (int a = 0; a <= RMAX; a++) begin
      e_st[a] = e;
      n_att = a + 1;
      cs = e + SETTLE;
      ce = cs + TIMEOUT - 1;
      if (r >= 0 && r + 2 <= ce) begin
        rdy_c = ((cs > r + 2) ? cs : r + 2) + 1;
        break;
      end
      if (a == RMAX) flt_c = ce + 1;
      else e = ce + 1 + SETTLE;
    end
  endtask

  function automatic logic [2:0] model_state(input int c);
    if (c >= rdy_c) return S_READY;
    if (c >= flt_c) return S_FAULT;
    if (c < e_st[0]) return S_LOAD;
    for (int a = 0; a < n_att; a++) begin
      if (c >= e_st[a] && c < e_st[a] + SETTLE) return S_ENABLE;
      if (c >= e_st[a] + SETTLE && c < e_st[a] + SETTLE + TIMEOUT) return S_CHECK;
      if (c >= e_st[a] + SETTLE + TIMEOUT && c < e_st[a] + 2 * SETTLE + TIMEOUT) return S_OFF;
    end
    return S_IDLE;
  endfunction

  // Channels below n carry the new words, the rest the old bus.
  function automatic logic [TRW-1:0] mix(input logic [TRW-1:0] nw, input logic [TRW-1:0] old, input int n);
    logic [TRW-1:0] v;
    for (int j = 0; j < NCH; j++) v[j*TW +: TW] = (j < n) ? nw[j*TW +: TW] : old[j*TW +: TW];
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  // Called in a LOAD cycle: strobes words now, then checks every cycle until
  // tail cycles past ready or fault.
  task automatic run_seq(input logic [TRW-1:0] words, input int r_off, input int tail);
    int             t;
    int             r_abs;
    int             c_end;
    logic [NCH-1:0] ten_prev;
    logic [2:0]     es;
    t = cyc;
    r_abs = (r_off < 0) ? -1 : t + r_off;
    trim_in = words;
    trim_vld = 1'b1;
    plan(t, r_abs);
    c_end = ((rdy_c < NEVER) ? rdy_c : flt_c) + tail;
    ten_prev = ten;
    while (cyc < c_end) begin
      tick();
      trim_vld = 1'b0;
      trim_in = TRW'($urandom());
      if (cyc == r_abs) refok = 1'b1;
      es = model_state(cyc);
      check("state", 32'(state_o), 32'(es));
      check("en", 32'(en), 32'(es == S_ENABLE || es == S_CHECK || es == S_READY));
      check("ready", 32'(ready), 32'(es == S_READY));
      check("fault", 32'(fault), 32'(es == S_FAULT));
      check("ten_out", 32'(ten_out), 32'((es == S_READY) ? ten_prev : '0));
      check("trim_out", 32'(trim_out), 32'(mix(words, cur_trim, cyc - t)));
      ten = NCH'($urandom());
      ten_prev = ten;
    end
    cur_trim = words;
  endtask

  // Called in READY: drop refok now, restore it back_off cycles later.
  task automatic loss_test(input int back_off);
    int             d;
    int             e;
    int             rb;
    logic [NCH-1:0] tp;
    logic [2:0]     es;
    d = cyc;
    refok = 1'b0;
    e = d + back_off;
    rb = (((d + 3) > (e + 2)) ? d + 3 : e + 2) + 1;
    tp = ten;
    while (cyc < rb + 2) begin
      tick();
      if (cyc == e) refok = 1'b1;
      es = (cyc >= d + 3 && cyc < rb) ? S_CHECK : S_READY;
      check("loss_state", 32'(state_o), 32'(es));
      check("loss_ready", 32'(ready), 32'(es == S_READY));
      check("loss_en", 32'(en), 32'(1));
      check("loss_ten_out", 32'(ten_out), 32'((es == S_READY) ? tp : '0));
      ten = NCH'($urandom());
      tp = ten;
    end
  endtask

  // Drop start; one cycle later the block is idle with trims retained.
  task automatic stop_seq();
    refok = 1'b0;
    start = 1'b0;
    tick();
    check("stop_state", 32'(state_o), 32'(S_IDLE));
    check("stop_en", 32'(en), 32'(0));
    check("stop_ready", 32'(ready), 32'(0));
    check("stop_fault", 32'(fault), 32'(0));
    check("stop_ten_out", 32'(ten_out), 32'(0));
    check("stop_trim", 32'(trim_out), 32'(cur_trim));
    tick();
    tick();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, 32'(state_o), 32'(S_IDLE));
    check({tag, "_en"}, 32'(en), 32'(0));
    check({tag, "_trim"}, 32'(trim_out), 32'(0));
    check({tag, "_ten_out"}, 32'(ten_out), 32'(0));
    check({tag, "_ready"}, 32'(ready), 32'(0));
    check({tag, "_fault"}, 32'(fault), 32'(0));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [TRW-1:0] words;
    int             t;
    rst = 1'b1;
    start = 1'b0;
    trim_vld = 1'b0;
    trim_in = '0;
    ten = '0;
    refok = 1'b0;
    cur_trim = '0;
`ifdef REF_TRIM_SEQ_TESTOVR_EN
    tm_ovr = 1'b0;
    tm_trim = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();

    // Nominal: strobe coinciding with start is ignored; fixed words.
    start = 1'b1;
    trim_in = TRW'($urandom());
    trim_vld = 1'b1;
    tick();
    trim_vld = 1'b0;
    check("first_load_state", 32'(state_o), 32'(S_LOAD));
    check("ignored_strobe", 32'(trim_out), 32'(cur_trim));
    repeat ($urandom_range(0, 3)) begin
      tick();
      check("wait_load_state", 32'(state_o), 32'(S_LOAD));
      check("wait_load_trim", 32'(trim_out), 32'(cur_trim));
    end
    words = {7'h01, 7'h7F, 7'h2A, 7'h15};
    run_seq(words, NCH + 1 + 5, 3);

    // Loss of refok while ready, then recovery.
    loss_test($urandom_range(1, 12));
    stop_seq();

    // Retry then pass: refok low through the first attempt.
    start = 1'b1;
    tick();
    run_seq(TRW'($urandom()), $urandom_range(51, 110), 3);
    check("retry_no_fault", 32'(fault), 32'(0));
    stop_seq();

    // Fault: refok never rises.
    start = 1'b1;
    tick();
    run_seq(TRW'($urandom()), -1, 3);
    stop_seq();

    // Abort while channel 2 is due.
    start = 1'b1;
    tick();
    t = cyc;
    words = TRW'($urandom());
    trim_in = words;
    trim_vld = 1'b1;
    tick();
    trim_vld = 1'b0;
    check("abort_ch0", 32'(trim_out), 32'(mix(words, cur_trim, 1)));
    tick();
    check("abort_ch1", 32'(trim_out), 32'(mix(words, cur_trim, 2)));
    start = 1'b0;
    tick();
    check("abort_state", 32'(state_o), 32'(S_IDLE));
    check("abort_en", 32'(en), 32'(0));
    check("abort_trim", 32'(trim_out), 32'(mix(words, cur_trim, cyc - t - 1)));
    cur_trim = mix(words, cur_trim, 2);
    tick();
    tick();

    // Randomized refok timing: any mix of pass, retry and fault.
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      tick();
      run_seq(TRW'($urandom()), $urandom_range(1, 200), 3);
      stop_seq();
    end

    // Reach READY, then asynchronous reset mid-cycle.
    start = 1'b1;
    tick();
    run_seq(TRW'($urandom()), $urandom_range(1, 20), 2);
`ifdef REF_TRIM_SEQ_TESTOVR_EN
    tm_trim = '0;
    tm_ovr = 1'b1;
    tick();
    check("ovr_trim", 32'(trim_out), 32'(0));
    tm_ovr = 1'b0;
    tick();
    check("ovr_restore", 32'(trim_out), 32'(cur_trim));
`endif
    check("pre_reset_ready", 32'(ready), 32'(1));
    #2;
    rst = 1'b1;
    start = 1'b0;
    #1;
    check_reset_values("async_reset");
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post_reset_state", 32'(state_o), 32'(S_IDLE));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
